ahb_lite_master: RTL and testbench

- Single-master AHB-Lite bus master. It sits directly upstream of the AHB slaves and drives their h_* bus.
- Converts a simple command stream (address, burst, size, direction) plus a write-data stream into pipelined AHB transfers.
- Returns read data beats and one completion/error status per command.

---
 rtl/ahb_lite_master.sv | 235 +++++++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-master AHB-Lite initiator. Turns a command stream plus
// a write-data stream into pipelined AHB bursts. Returns read beats and one
// completion/error status per command.
module ahb_lite_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  h_clk,
  input  logic                  h_resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_burst,
  input  logic [2:0]            cmd_size,
  input  logic [4:0]            cmd_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_W-1:0]     wd_data,
  input  logic [DATA_W/8-1:0]   wd_strb,
  output logic [ADDR_W-1:0]     h_addr,
  output logic [2:0]            h_burst,
  output logic [2:0]            h_size,
  output logic [1:0]            h_trans,
  output logic                  h_write,
  output logic [DATA_W-1:0]     h_wdata,
  output logic [DATA_W/8-1:0]   h_wstrb,
  input  logic [DATA_W-1:0]     h_rdata,
  input  logic                  h_ready,
  input  logic                  h_resp,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  done_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LAST,
    S_ABORT,
    S_REJ
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q, wrap_mask_q, addr_inc, addr_nxt, cmd_mask;
  logic [2:0]          burst_q, size_q;
  logic                write_q, wrap_q;
  logic [4:0]          beats_left_q, cmd_beats;
  logic                first_q, issued_q, dp_active_q, dp_last_q, out_en_q;
  logic                cmd_take, cmd_rej, ap_take, dp_ok, dp_err, fin, fin_err;

  assign h_addr  = addr_q;
  assign h_burst = burst_q;
  assign h_size  = size_q;
  assign h_write = write_q;

  assign cmd_rej = (cmd_size > 3'd2);
  assign dp_err  = dp_active_q && h_resp;

  // Beat count and wrap-boundary mask derived from the incoming command
  always_comb begin
    case (cmd_burst[2:1])
      2'b00:   cmd_beats = (cmd_burst[0] && (cmd_len != '0)) ? cmd_len : 5'd1;
      2'b01:   cmd_beats = 5'd4;
      2'b10:   cmd_beats = 5'd8;
      default: cmd_beats = 5'd16;
    endcase
    cmd_mask = (ADDR_W'(cmd_beats) << cmd_size) - ADDR_W'(1);
  end

  // Next beat address: linear increment, folded into the aligned window for WRAP
  always_comb begin
    addr_inc = addr_q + (ADDR_W'(1) << size_q);
    addr_nxt = wrap_q ? ((addr_q & ~wrap_mask_q) | (addr_inc & wrap_mask_q))
                      : addr_inc;
  end

  // State register
  always_ff @(posedge h_clk) begin
    if (!h_resetn) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic, bus transfer type and handshake strobes
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wd_ready  = 1'b0;
    h_trans   = TR_IDLE;
    cmd_take  = 1'b0;
    ap_take   = 1'b0;
    dp_ok     = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = out_en_q;
        if (cmd_valid && out_en_q) begin
          cmd_take = 1'b1;
          if (cmd_rej) begin
            state_nxt = S_REJ;
            fin       = 1'b1;
            fin_err   = 1'b1;
          end else begin
            state_nxt = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        // Once a NONSEQ/SEQ has been shown under wait states it is locked,
        // so a late drop of wd_valid cannot retract it.
        if (issued_q || !write_q || wd_valid) h_trans = first_q ? TR_NONSEQ : TR_SEQ;
        else                                  h_trans = first_q ? TR_IDLE : TR_BUSY;
        if (dp_err) begin
          if (h_ready) begin
            fin       = 1'b1;
            fin_err   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_ABORT;
          end
        end else if (h_ready) begin
          dp_ok = dp_active_q;
          if (h_trans[1]) begin
            ap_take  = 1'b1;
            wd_ready = write_q;
            if (beats_left_q == 5'd1) state_nxt = S_LAST;
          end
        end
      end
      S_LAST: begin
        if (dp_err) begin
          if (h_ready) begin
            fin       = 1'b1;
            fin_err   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_ABORT;
          end
        end else if (h_ready) begin
          dp_ok     = 1'b1;
          fin       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_ABORT: begin
        if (h_ready) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_REJ: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Burst bookkeeping, data-phase tracking, write-data and read-return registers
  always_ff @(posedge h_clk) begin
    if (!h_resetn) begin
      out_en_q     <= 1'b0;
      addr_q       <= '0;
      burst_q      <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      wrap_q       <= 1'b0;
      wrap_mask_q  <= '0;
      beats_left_q <= '0;
      first_q      <= 1'b0;
      issued_q     <= 1'b0;
      dp_active_q  <= 1'b0;
      dp_last_q    <= 1'b0;
      h_wdata      <= '0;
      h_wstrb      <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_last      <= 1'b0;
      done         <= 1'b0;
      done_err     <= 1'b0;
    end else begin
      out_en_q <= 1'b1;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= fin;
      done_err <= fin_err;

      if (cmd_take && !cmd_rej) begin
        addr_q       <= cmd_addr;
        burst_q      <= cmd_burst;
        size_q       <= cmd_size;
        write_q      <= cmd_write;
        wrap_q       <= !cmd_burst[0] && (cmd_burst[2:1] != 2'b00);
        wrap_mask_q  <= cmd_mask;
        beats_left_q <= cmd_beats;
        first_q      <= 1'b1;
        issued_q     <= 1'b0;
      end

      if (ap_take) begin
        addr_q       <= addr_nxt;
        beats_left_q <= beats_left_q - 5'd1;
        dp_last_q    <= (beats_left_q == 5'd1);
        first_q      <= 1'b0;
        issued_q     <= 1'b0;
        if (write_q) begin
          h_wdata <= wd_data;
          h_wstrb <= wd_strb;
        end
      end else if (h_trans[1] && !h_ready) begin
        issued_q <= 1'b1;
      end

      if (ap_take)      dp_active_q <= 1'b1;
      else if (h_ready) dp_active_q <= 1'b0;

      if (dp_ok && !write_q) begin
        rd_valid <= 1'b1;
        rd_data  <= h_rdata;
        rd_last  <= dp_last_q;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed self-checking bench for ahb_lite_master.
module tb_ahb_lite_master;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic        h_clk = 1'b0;
  logic        h_resetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_burst, cmd_size;
  logic [4:0]  cmd_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic [31:0] h_addr, h_wdata, h_rdata, rd_data;
  logic [2:0]  h_burst, h_size;
  logic [1:0]  h_trans;
  logic        h_write, h_ready, h_resp;
  logic [3:0]  h_wstrb;
  logic        rd_valid, rd_last, done, done_err;

  int unsigned n_run = 0;
  int unsigned n_fail = 0;
  int unsigned rd_cnt, done_cnt, wr_cnt;

  // Test 2: INCR4 read, one wait state per beat (cycles 1..9 after NONSEQ)
  logic [1:0]  t2_trans [9] = '{TR_SEQ, TR_SEQ, TR_SEQ, TR_SEQ, TR_SEQ, TR_SEQ,
                                TR_IDLE, TR_IDLE, TR_IDLE};
  logic [31:0] t2_addr  [6] = '{32'h14, 32'h14, 32'h18, 32'h18, 32'h1C, 32'h1C};
  logic        t2_rdv   [9] = '{0, 0, 1, 0, 1, 0, 1, 0, 1};

  // Test 3: WRAP4 write from 0x38 with wd_valid gap (cycles 0..7)
  logic        t3_wdv   [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  logic [31:0] t3_wdd   [8] = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hBAD0_BAD0, 32'hBAD0_BAD0,
                                32'hA5A5_0002, 32'hA5A5_0003, 32'h0, 32'h0};
  logic [3:0]  t3_wds   [8] = '{4'hF, 4'h3, 4'h0, 4'h0, 4'hC, 4'h1, 4'h0, 4'h0};
  logic [1:0]  t3_trans [8] = '{TR_NONSEQ, TR_SEQ, TR_BUSY, TR_BUSY, TR_SEQ, TR_SEQ,
                                TR_IDLE, TR_IDLE};
  logic [31:0] t3_addr  [6] = '{32'h38, 32'h3C, 32'h30, 32'h30, 32'h30, 32'h34};
  logic        t3_wrdy  [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  logic [31:0] t3_hwd   [8] = '{32'h0, 32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0001,
                                32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'h0};
  logic [3:0]  t3_hws   [8] = '{4'h0, 4'hF, 4'h3, 4'h3, 4'h3, 4'hC, 4'h1, 4'h0};

  // Test 4: INCR8 write, ERROR on beat 3 (cycles 0..6)
  logic        t4_rdy   [7] = '{1, 1, 1, 0, 1, 1, 1};
  logic        t4_resp  [7] = '{0, 0, 0, 1, 1, 0, 0};
  logic [1:0]  t4_trans [7] = '{TR_NONSEQ, TR_SEQ, TR_SEQ, TR_SEQ, TR_IDLE, TR_IDLE, TR_IDLE};
  logic [31:0] t4_addr  [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
  logic        t4_wrdy  [7] = '{1, 1, 1, 0, 0, 0, 0};
  logic [31:0] t4_hwd   [4] = '{32'h0, 32'h3F00_0000, 32'h3F00_0001, 32'h3F00_0002};
  logic        t4_done  [7] = '{0, 0, 0, 0, 0, 1, 0};

  always #5 h_clk = ~h_clk;

  ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .h_clk(h_clk), .h_resetn(h_resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .h_addr(h_addr), .h_burst(h_burst), .h_size(h_size), .h_trans(h_trans),
    .h_write(h_write), .h_wdata(h_wdata), .h_wstrb(h_wstrb),
    .h_rdata(h_rdata), .h_ready(h_ready), .h_resp(h_resp),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_err(done_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge h_clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_burst = '0;   cmd_size = '0; cmd_len = '0;
    wd_valid  = 1'b0; wd_data = '0;  wd_strb = '0;
    h_rdata   = '0;   h_ready = 1'b1; h_resp = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic w, input logic [2:0] b,
                          input logic [2:0] s, input logic [4:0] l);
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w;
    cmd_burst = b;    cmd_size = s; cmd_len = l;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " h_trans"},  32'(h_trans),   32'h0);
    chk({tag, " h_addr"},   h_addr,         32'h0);
    chk({tag, " h_burst"},  32'(h_burst),   32'h0);
    chk({tag, " h_size"},   32'(h_size),    32'h0);
    chk({tag, " h_write"},  32'(h_write),   32'h0);
    chk({tag, " h_wdata"},  h_wdata,        32'h0);
    chk({tag, " h_wstrb"},  32'(h_wstrb),   32'h0);
    chk({tag, " cmd_ready"},32'(cmd_ready), 32'h0);
    chk({tag, " wd_ready"}, 32'(wd_ready),  32'h0);
    chk({tag, " rd_valid"}, 32'(rd_valid),  32'h0);
    chk({tag, " rd_last"},  32'(rd_last),   32'h0);
    chk({tag, " done"},     32'(done),      32'h0);
    chk({tag, " done_err"}, 32'(done_err),  32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    h_resetn = 1'b0;
    tick();
    tick();
    #1;
    chk_quiet("reset");
    h_resetn = 1'b1;

    // Test 1: SINGLE word write, zero-wait slave
    tick();
    send_cmd(32'h4, 1'b1, 3'b000, 3'd2, 5'd0);
    wd_valid = 1'b1; wd_data = 32'h1234_5678; wd_strb = 4'hF;
    #1;
    chk("t1 cmd_ready", 32'(cmd_ready), 32'h1);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("t1 c0 h_trans", 32'(h_trans), 32'(TR_NONSEQ));
    chk("t1 c0 h_addr", h_addr, 32'h4);
    chk("t1 c0 h_write", 32'(h_write), 32'h1);
    chk("t1 c0 h_size", 32'(h_size), 32'h2);
    chk("t1 c0 wd_ready", 32'(wd_ready), 32'h1);
    tick();
    wd_valid = 1'b0;
    #1;
    chk("t1 c1 h_trans", 32'(h_trans), 32'(TR_IDLE));
    chk("t1 c1 h_wdata", h_wdata, 32'h1234_5678);
    chk("t1 c1 h_wstrb", 32'(h_wstrb), 32'hF);
    chk("t1 c1 done", 32'(done), 32'h0);
    tick();
    #1;
    chk("t1 c2 done", 32'(done), 32'h1);
    chk("t1 c2 done_err", 32'(done_err), 32'h0);
    chk("t1 c2 cmd_ready", 32'(cmd_ready), 32'h1);

    // Test 2: INCR4 read from 0x10, one wait state per beat
    tick();
    send_cmd(32'h10, 1'b0, 3'b011, 3'd2, 5'd0);
    #1;
    tick();
    cmd_valid = 1'b0;
    h_ready = 1'b1;
    #1;
    chk("t2 c0 h_trans", 32'(h_trans), 32'(TR_NONSEQ));
    chk("t2 c0 h_addr", h_addr, 32'h10);
    chk("t2 c0 h_burst", 32'(h_burst), 32'h3);
    rd_cnt = 0;
    done_cnt = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      h_ready = ((c % 2) == 0) || (c == 9);
      h_rdata = ((c % 2) == 0) ? 32'hD000_0000 + 32'(c) : 32'hDEAD_0000;
      #1;
      chk($sformatf("t2 c%0d h_trans", c), 32'(h_trans), 32'(t2_trans[c-1]));
      if (c <= 6) chk($sformatf("t2 c%0d h_addr", c), h_addr, t2_addr[c-1]);
      chk($sformatf("t2 c%0d rd_valid", c), 32'(rd_valid), 32'(t2_rdv[c-1]));
      if (t2_rdv[c-1]) begin
        chk($sformatf("t2 c%0d rd_data", c), rd_data, 32'hD000_0000 + 32'(c - 1));
        chk($sformatf("t2 c%0d rd_last", c), 32'(rd_last), 32'(c == 9));
      end
      if (rd_valid) rd_cnt++;
      if (done) done_cnt++;
    end
    chk("t2 rd pulses", rd_cnt, 32'd4);
    chk("t2 done pulses", done_cnt, 32'd1);
    chk("t2 done_err", 32'(done_err), 32'h0);

    // Test 3: WRAP4 write from 0x38, wd_valid gap before beat 3
    tick();
    h_ready = 1'b1;
    send_cmd(32'h38, 1'b1, 3'b010, 3'd2, 5'd0);
    wd_valid = 1'b1; wd_data = t3_wdd[0]; wd_strb = t3_wds[0];
    #1;
    for (int c = 0; c <= 7; c++) begin
      tick();
      cmd_valid = 1'b0;
      wd_valid = t3_wdv[c];
      wd_data  = t3_wdd[c];
      wd_strb  = t3_wds[c];
      #1;
      chk($sformatf("t3 c%0d h_trans", c), 32'(h_trans), 32'(t3_trans[c]));
      if (c <= 5) chk($sformatf("t3 c%0d h_addr", c), h_addr, t3_addr[c]);
      chk($sformatf("t3 c%0d wd_ready", c), 32'(wd_ready), 32'(t3_wrdy[c]));
      if ((c >= 1) && (c <= 6)) begin
        chk($sformatf("t3 c%0d h_wdata", c), h_wdata, t3_hwd[c]);
        chk($sformatf("t3 c%0d h_wstrb", c), 32'(h_wstrb), 32'(t3_hws[c]));
      end
      chk($sformatf("t3 c%0d done", c), 32'(done), 32'(c == 7));
    end

    // Test 4: INCR8 write from 0x100, ERROR response on beat 3
    tick();
    send_cmd(32'h100, 1'b1, 3'b101, 3'd2, 5'd0);
    wd_valid = 1'b1; wd_data = 32'h3F00_0000; wd_strb = 4'hF;
    #1;
    wr_cnt = 0;
    for (int c = 0; c <= 6; c++) begin
      tick();
      cmd_valid = 1'b0;
      wd_data = 32'h3F00_0000 + 32'(c);
      h_ready = t4_rdy[c];
      h_resp  = t4_resp[c];
      #1;
      chk($sformatf("t4 c%0d h_trans", c), 32'(h_trans), 32'(t4_trans[c]));
      if (c <= 3) chk($sformatf("t4 c%0d h_addr", c), h_addr, t4_addr[c]);
      if ((c >= 1) && (c <= 3)) chk($sformatf("t4 c%0d h_wdata", c), h_wdata, t4_hwd[c]);
      chk($sformatf("t4 c%0d wd_ready", c), 32'(wd_ready), 32'(t4_wrdy[c]));
      chk($sformatf("t4 c%0d done", c), 32'(done), 32'(t4_done[c]));
      if (t4_done[c]) chk($sformatf("t4 c%0d done_err", c), 32'(done_err), 32'h1);
      if (wd_ready) wr_cnt++;
    end
    chk("t4 wd_ready pulses", wr_cnt, 32'd3);
    wd_valid = 1'b0;
    h_ready = 1'b1;
    h_resp = 1'b0;

    // Test 5: unsupported size is rejected locally
    tick();
    send_cmd(32'h40, 1'b0, 3'b000, 3'b110, 5'd0);
    #1;
    chk("t5 cmd_ready", 32'(cmd_ready), 32'h1);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("t5 c1 h_trans", 32'(h_trans), 32'(TR_IDLE));
    chk("t5 c1 done", 32'(done), 32'h1);
    chk("t5 c1 done_err", 32'(done_err), 32'h1);
    tick();
    #1;
    chk("t5 c2 h_trans", 32'(h_trans), 32'(TR_IDLE));
    chk("t5 c2 done", 32'(done), 32'h0);
    chk("t5 c2 cmd_ready", 32'(cmd_ready), 32'h1);

    // Test 6: reset in the middle of an INCR16 read, then a fresh SINGLE read
    tick();
    send_cmd(32'h400, 1'b0, 3'b111, 3'd2, 5'd0);
    #1;
    tick();
    cmd_valid = 1'b0;
    h_rdata = 32'h1111_1111;
    #1;
    chk("t6 c0 h_trans", 32'(h_trans), 32'(TR_NONSEQ));
    chk("t6 c0 h_burst", 32'(h_burst), 32'h7);
    tick();
    #1;
    chk("t6 c1 h_addr", h_addr, 32'h404);
    tick();
    #1;
    chk("t6 c2 h_addr", h_addr, 32'h408);
    chk("t6 c2 rd_valid", 32'(rd_valid), 32'h1);
    tick();
    h_resetn = 1'b0;
    #1;
    tick();
    #1;
    chk_quiet("t6 reset");
    h_resetn = 1'b1;
    tick();
    #1;
    chk("t6 post h_trans", 32'(h_trans), 32'(TR_IDLE));
    chk("t6 post done", 32'(done), 32'h0);
    chk("t6 post rd_valid", 32'(rd_valid), 32'h0);
    chk("t6 post cmd_ready", 32'(cmd_ready), 32'h1);
    send_cmd(32'h200, 1'b0, 3'b000, 3'd2, 5'd0);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("t6 s0 h_trans", 32'(h_trans), 32'(TR_NONSEQ));
    chk("t6 s0 h_addr", h_addr, 32'h200);
    chk("t6 s0 h_write", 32'(h_write), 32'h0);
    chk("t6 s0 h_burst", 32'(h_burst), 32'h0);
    tick();
    h_rdata = 32'hCAFE_F00D;
    #1;
    chk("t6 s1 h_trans", 32'(h_trans), 32'(TR_IDLE));
    chk("t6 s1 rd_valid", 32'(rd_valid), 32'h0);
    tick();
    #1;
    chk("t6 s2 rd_valid", 32'(rd_valid), 32'h1);
    chk("t6 s2 rd_data", rd_data, 32'hCAFE_F00D);
    chk("t6 s2 rd_last", 32'(rd_last), 32'h1);
    chk("t6 s2 done", 32'(done), 32'h1);
    chk("t6 s2 done_err", 32'(done_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
